// File: rtl/ping_trigger_buffer.sv
// ping_trigger_buffer
// Circular capture buffer for the octal 14-bit ADC sample stream. Every
// sample written while a capture is in progress lands in a DEPTH-word ring.
// After arming, PRE_TRIG samples are collected first. The first enabled
// channel whose magnitude about mid-scale reaches the threshold then
// freezes a frame of DEPTH words around that sample. The frame is streamed
// out over a valid/ready interface.
//
// Ports
//   clk, rst        sample-domain clock, synchronous active-high reset
//   sample_valid    strobe qualifying din
//   din[111:0]      channels A..H, 14 bits each, A in the LSBs, offset binary
//   arm             start a capture (IDLE only)
//   threshold[13:0] magnitude threshold (>=)
//   trig_mask[7:0]  per-channel trigger enable, bit0 = A
//   busy            not IDLE
//   triggered       sticky trigger flag, cleared on return to IDLE
//   trig_chan[2:0]  lowest enabled channel that hit on the trigger sample
//   trig_time[31:0] sample counter value of the trigger sample
//   rd_valid/rd_ready/rd_data[111:0]/rd_last  frame readout stream
//
// state   | meaning
// IDLE    | waiting for arm, samples dropped
// FILL    | collecting the PRE_TRIG pre-trigger samples, hits ignored
// ARMED   | writing samples, first hit triggers
// POST    | writing the post-trigger samples
// READOUT | streaming the frozen frame, samples dropped

module ping_trigger_buffer #(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_TRIG   = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [111:0] din,
    input  logic         arm,
    input  logic [13:0]  threshold,
    input  logic [7:0]   trig_mask,
    output logic         busy,
    output logic         triggered,
    output logic [2:0]   trig_chan,
    output logic [31:0]  trig_time,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [111:0] rd_data,
    output logic         rd_last
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;

    localparam logic [AW:0]   PRE_CNT  = (AW + 1)'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_OFS  = AW'(PRE_TRIG);
    localparam logic [AW-1:0] POST_LEN = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW:0]   LAST_IDX = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic          NO_PRE   = (PRE_TRIG == 0);
    localparam logic          NO_POST  = (DEPTH - PRE_TRIG - 1 == 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_POST    = 3'd3;
    localparam logic [2:0] S_READOUT = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] post_cnt;
    logic [AW:0]   fill_cnt;
    logic [AW:0]   fetch_cnt;
    logic [31:0]   sample_cnt;
    logic [111:0]  mem [DEPTH];

    logic [14:0]   sgn [8];
    logic [14:0]   mag [8];
    logic [7:0]    hit;
    logic [2:0]    hit_chan;
    logic          wr_en;

    // Offset binary to signed by subtracting mid-scale; mag spans 0..8192,
    // so the compare is done one bit wider than the threshold.
    always_comb begin
        hit = '0;
        for (int c = 0; c < 8; c++) begin
            sgn[c] = {1'b0, din[c*14 +: 14]} - 15'd8192;
            mag[c] = sgn[c][14] ? (15'd0 - sgn[c]) : sgn[c];
            hit[c] = trig_mask[c] && (mag[c] >= {1'b0, threshold});
        end
    end

    always_comb begin
        hit_chan = 3'd0;
        for (int c = 7; c >= 0; c--) begin
            if (hit[c]) hit_chan = 3'(c);
        end
    end

    assign wr_en = sample_valid &&
                   (state == S_FILL || state == S_ARMED || state == S_POST);
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            post_cnt   <= '0;
            fill_cnt   <= '0;
            fetch_cnt  <= '0;
            sample_cnt <= '0;
            triggered  <= 1'b0;
            trig_chan  <= '0;
            trig_time  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
        end else begin
            if (sample_valid) sample_cnt <= sample_cnt + 32'd1;
            if (wr_en) wptr <= wptr + ONE;

            case (state)
                S_IDLE: begin
                    if (arm) begin
                        fill_cnt <= '0;
                        state    <= NO_PRE ? S_ARMED : S_FILL;
                    end
                end
                S_FILL: begin
                    if (wr_en) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt + 1'b1 == PRE_CNT) state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (wr_en && |hit) begin
                        triggered <= 1'b1;
                        trig_chan <= hit_chan;
                        trig_time <= sample_cnt;
                        // Frame start is fixed now, while wptr still
                        // addresses the trigger sample.
                        rptr      <= wptr - PRE_OFS;
                        post_cnt  <= POST_LEN;
                        fetch_cnt <= '0;
                        state     <= NO_POST ? S_READOUT : S_POST;
                    end
                end
                S_POST: begin
                    if (wr_en) begin
                        post_cnt <= post_cnt - ONE;
                        if (post_cnt == ONE) state <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    // rd_data is the registered memory read, refilled only
                    // when the output is empty or being consumed.
                    if (rd_valid && rd_ready && rd_last) begin
                        state     <= S_IDLE;
                        rd_valid  <= 1'b0;
                        rd_last   <= 1'b0;
                        triggered <= 1'b0;
                    end else if ((!rd_valid || rd_ready) && fetch_cnt != FULL_CNT) begin
                        rd_data   <= mem[rptr];
                        rd_valid  <= 1'b1;
                        rd_last   <= (fetch_cnt == LAST_IDX);
                        rptr      <= rptr + ONE;
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ping_trigger_buffer.sv
// Bench for ping_trigger_buffer with DEPTH = 16 and PRE_TRIG = 4. A frame is
// predicted from the list of samples fed since arm. The first PRE_TRIG
// samples fill the pre-trigger history. The trigger is the first later
// sample with an enabled channel at |value - 8192| >= threshold. The frame
// is the PRE_TRIG samples before it, the trigger sample and the samples
// after it.

module tb_ping_trigger_buffer;
    localparam int DL2   = 4;
    localparam int PRE   = 4;
    localparam int DEPTH = 16;
    localparam int POSTN = DEPTH - PRE - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sample_valid = 1'b0;
    logic [111:0] din = '0;
    logic         arm = 1'b0;
    logic [13:0]  threshold = '0;
    logic [7:0]   trig_mask = '0;
    logic         busy, triggered, rd_valid, rd_last;
    logic         rd_ready = 1'b1;
    logic [2:0]   trig_chan;
    logic [31:0]  trig_time;
    logic [111:0] rd_data;

    ping_trigger_buffer #(.DEPTH_LOG2(DL2), .PRE_TRIG(PRE)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .din(din),
        .arm(arm), .threshold(threshold), .trig_mask(trig_mask),
        .busy(busy), .triggered(triggered), .trig_chan(trig_chan),
        .trig_time(trig_time), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sc       = 0;
    logic [111:0] stim_q[$];

    typedef struct {
        logic [111:0] inj;
        logic [13:0]  thr;
        logic [7:0]   mask;
        int           exp_idx;
        int           exp_chan;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [111:0] all_ch(input logic [13:0] v);
        logic [111:0] r;
        for (int c = 0; c < 8; c++) r[c*14 +: 14] = v;
        return r;
    endfunction

    function automatic logic [111:0] set_ch(input logic [111:0] w, input int c, input logic [13:0] v);
        w[c*14 +: 14] = v;
        return w;
    endfunction

    function automatic vec_t mk_vec(input logic [111:0] inj, input logic [13:0] thr,
                                    input logic [7:0] mask, input int idx, input int chan);
        vec_t v;
        v.inj = inj; v.thr = thr; v.mask = mask; v.exp_idx = idx; v.exp_chan = chan;
        return v;
    endfunction

    task automatic build_base(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(all_ch(14'h2000 + 14'(i)));
    endtask

    function automatic int find_trig(input int thr, input logic [7:0] mask, output int chan);
        int m;
        chan = 0;
        for (int j = PRE; j < stim_q.size(); j++) begin
            for (int c = 0; c < 8; c++) begin
                m = int'(stim_q[j][c*14 +: 14]) - 8192;
                if (m < 0) m = -m;
                if (mask[c] && m >= thr) begin
                    chan = c;
                    return j;
                end
            end
        end
        return -1;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sc = 0;
    endtask

    task automatic feed(input bit gaps);
        for (int i = 0; i < stim_q.size(); i++) begin
            sample_valid = 1'b1;
            din = stim_q[i];
            tick;
            sc++;
            sample_valid = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) tick;
        end
        sample_valid = 1'b0;
    endtask

    task automatic collect(input int ready_pct, input int exp_idx, input bit arm_in_ro);
        int hs = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [111:0] pd = '0;
        logic pl = 1'b0;
        while (hs < DEPTH && cyc < 3000) begin
            if (stalled) begin
                check("stall_valid", rd_valid, 1);
                check("stall_data", rd_data, pd);
                check("stall_last", rd_last, pl);
            end
            rd_ready = ($urandom_range(0, 99) < ready_pct);
            arm = arm_in_ro && hs == 5 && rd_valid;
            if (rd_valid && rd_ready) begin
                if (hs == 0) check("triggered_sticky", triggered, 1);
                check($sformatf("word%0d", hs), rd_data, stim_q[exp_idx - PRE + hs]);
                check($sformatf("rd_last%0d", hs), rd_last, hs == DEPTH - 1);
                hs++;
            end
            stalled = rd_valid && !rd_ready;
            pd = rd_data;
            pl = rd_last;
            tick;
            cyc++;
        end
        arm = 1'b0;
        rd_ready = 1'b1;
        check("handshakes", hs, DEPTH);
        check("end_busy", busy, 0);
        check("end_triggered", triggered, 0);
        check("end_valid", rd_valid, 0);
    endtask

    task automatic run_capture(input int ready_pct, input int exp_idx, input int exp_chan,
                               input bit arm_in_ro, input bit gaps);
        int sc0;
        bit complete;
        complete = (exp_idx >= PRE) && (exp_idx + POSTN < stim_q.size());
        arm = 1'b1;
        tick;
        arm = 1'b0;
        check("busy_after_arm", busy, 1);
        sc0 = sc;
        if (!complete) begin
            feed(gaps);
            check("waiting_busy", busy, 1);
            check("waiting_valid", rd_valid, 0);
            check("waiting_trig", triggered, exp_idx >= 0);
            do_reset();
            check("abort_busy", busy, 0);
        end else begin
            fork
                feed(gaps);
                collect(ready_pct, exp_idx, arm_in_ro);
            join
            check("trig_chan", trig_chan, exp_chan);
            check("trig_time", trig_time, sc0 + exp_idx);
            tick;
            tick;
            check("idle_hold", busy, 0);
        end
    endtask

    initial begin
        logic [127:0] r128;
        int j, ch, thr;

        // Reset with random inputs and arm held high
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
            din = r128[111:0];
            sample_valid = 1'($urandom_range(0, 1));
            arm = 1'b1;
            threshold = 14'($urandom());
            trig_mask = 8'($urandom());
            rd_ready = 1'($urandom_range(0, 1));
            tick;
            check("rst_busy", busy, 0);
            check("rst_triggered", triggered, 0);
            check("rst_chan", trig_chan, 0);
            check("rst_time", trig_time, 0);
            check("rst_valid", rd_valid, 0);
            check("rst_data", rd_data, 0);
            check("rst_last", rd_last, 0);
        end
        rst = 1'b0;
        arm = 1'b0;
        sample_valid = 1'b0;
        rd_ready = 1'b1;
        sc = 0;
        tick;
        check("post_rst_busy", busy, 0);

        // Trigger-pattern table: the injected word replaces sample 10
        vecs.push_back(mk_vec(set_ch(all_ch(14'h2000), 2, 14'h2000 + 14'd500), 14'd400, 8'hFF, 10, 2));
        vecs.push_back(mk_vec(set_ch(all_ch(14'h2000), 7, 14'h1E6F), 14'd401, 8'hFF, 10, 7));
        vecs.push_back(mk_vec(set_ch(all_ch(14'h2000), 7, 14'h1E6F), 14'd401, 8'h7F, -1, 0));
        vecs.push_back(mk_vec(set_ch(all_ch(14'h2000), 7, 14'h1E6F), 14'd402, 8'hFF, -1, 0));
        vecs.push_back(mk_vec(set_ch(all_ch(14'h2000), 0, 14'h0000), 14'd8192, 8'h01, 10, 0));
        vecs.push_back(mk_vec(set_ch(all_ch(14'h2000), 0, 14'h3FFF), 14'd8192, 8'h01, -1, 0));
        vecs.push_back(mk_vec(set_ch(set_ch(all_ch(14'h2000), 2, 14'h2000 + 14'd300), 5, 14'h2000 - 14'd300),
                              14'd300, 8'hFF, 10, 2));
        vecs.push_back(mk_vec(set_ch(set_ch(all_ch(14'h2000), 2, 14'h2000 + 14'd300), 5, 14'h2000 - 14'd300),
                              14'd300, 8'hFB, 10, 5));
        vecs.push_back(mk_vec(all_ch(14'h2000 + 14'd10), 14'd0, 8'h10, 4, 4));

        for (int v = 0; v < vecs.size(); v++) begin
            build_base(41);
            stim_q[10] = vecs[v].inj;
            threshold = vecs[v].thr;
            trig_mask = vecs[v].mask;
            run_capture(100, vecs[v].exp_idx, vecs[v].exp_chan, 1'b0, 1'b0);
        end

        // Crossing during FILL is ignored, the later one triggers
        build_base(41);
        stim_q[1] = set_ch(all_ch(14'h2000), 2, 14'h2000 + 14'd500);
        stim_q[6] = set_ch(all_ch(14'h2000 + 14'd6), 2, 14'h2000 + 14'd500);
        threshold = 14'd400;
        trig_mask = 8'hFF;
        run_capture(100, 6, 2, 1'b0, 1'b0);

        // Backpressure with the basic trigger sequence
        build_base(41);
        stim_q[10] = vecs[0].inj;
        run_capture(30, 10, 2, 1'b0, 1'b0);

        // Abort during POST, then a clean capture with arm pulsed in READOUT
        build_base(13);
        stim_q[10] = vecs[0].inj;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        feed(1'b0);
        check("post_before_abort", triggered, 1);
        rst = 1'b1;
        tick;
        check("abort_busy", busy, 0);
        check("abort_valid", rd_valid, 0);
        check("abort_triggered", triggered, 0);
        check("abort_chan", trig_chan, 0);
        rst = 1'b0;
        sc = 0;
        build_base(41);
        stim_q[10] = vecs[0].inj;
        run_capture(100, 10, 2, 1'b1, 1'b0);

        // Random traffic against the reference model
        for (int it = 0; it < 8; it++) begin
            stim_q.delete();
            for (int i = 0; i < 60; i++) begin
                for (int c = 0; c < 8; c++)
                    r128[c*14 +: 14] = 14'(8192 + int'($urandom_range(0, 800)) - 400);
                stim_q.push_back(r128[111:0]);
            end
            thr = int'($urandom_range(200, 380));
            threshold = 14'(thr);
            trig_mask = 8'($urandom_range(1, 255));
            j = find_trig(thr, trig_mask, ch);
            run_capture(50, j, ch, 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ping_trigger_buffer.md
Name: ping_trigger_buffer

Overview:
- Sits directly downstream of the octal LVDS ADC capture stage.
- Accepts one 8-channel, 14-bit offset-binary sample per load strobe and writes every sample into a circular buffer.
- Once armed, the first threshold crossing on an enabled channel freezes a frame of DEPTH samples: PRE_TRIG samples before the trigger, the trigger sample, and DEPTH-PRE_TRIG-1 samples after it.
- The frozen frame is then read out to the host interface over a valid/ready stream.

Parameters:
- DEPTH_LOG2, 10, log2 of frame length; DEPTH = 2**DEPTH_LOG2 words.
- PRE_TRIG, 256, samples kept ahead of the trigger sample; legal range 0..DEPTH-1.

Ports:
- clk  in  1  sample-domain clock (capture stage frame clock).
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: din holds a new sample.
- din  in  112  channels A..H packed; A = [13:0], H = [111:98]; offset binary.
- arm  in  1  pulse that starts a capture; honoured only in IDLE.
- threshold  in  14  magnitude threshold, compared >=.
- trig_mask  in  8  per-channel trigger enable; bit0 = A.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  sticky; set at trigger, cleared on return to IDLE.
- trig_chan  out  3  lowest-index enabled channel that crossed threshold in the trigger sample.
- trig_time  out  32  sample counter value latched at the trigger sample.
- rd_valid  out  1  readout word available.
- rd_ready  in  1  consumer accepts the word.
- rd_data  out  112  frame word, same packing as din.
- rd_last  out  1  high with the final (DEPTH-th) frame word.

Behaviour:
- Reset: state IDLE; all outputs 0; wptr, fill count and sample counter all 0; memory contents don't-care. Reset mid-operation aborts immediately; the frame is lost.
- Sample counter: 32-bit, increments on every sample_valid in every state, wraps at 2**32.
- Magnitude per channel:
  - s = din_ch - 8192, 15-bit signed.
  - mag = |s|, 0..8192.
  - A channel hits when trig_mask bit = 1 and mag >= threshold.
- Write: every sample_valid in FILL, ARMED or POST writes din to mem[wptr], then wptr++ mod DEPTH. Samples in IDLE or READOUT are dropped and wptr holds.
- IDLE: on arm go to FILL and clear the fill count. If PRE_TRIG = 0, go directly to ARMED.
- FILL: each written sample increments the fill count; the state moves to ARMED in the cycle the count reaches PRE_TRIG. Hits in FILL are ignored.
- ARMED: on the first written sample with any hit:
  - trigger address T = that sample's wptr;
  - latch trig_chan and trig_time, set triggered;
  - post count = DEPTH-PRE_TRIG-1;
  - go to POST, or to READOUT if the post count is 0.
  - With threshold = 0, the first written ARMED sample triggers on any enabled channel.
- POST: each written sample decrements the post count; at 0 go to READOUT. Further hits are ignored.
- READOUT:
  - rptr starts at (T - PRE_TRIG) mod DEPTH; words are read sequentially with wrap.
  - Memory read latency is 1 cycle; rd_valid rises no later than 2 cycles after READOUT entry.
  - rd_data, rd_last and rd_valid stay stable while rd_valid & !rd_ready.
  - Exactly DEPTH handshakes, with no gaps required and no duplicates.
  - Frame word PRE_TRIG is the trigger sample.
  - rd_last is asserted only on word DEPTH-1.
  - The cycle after the last handshake: IDLE, busy = 0, triggered = 0, rd_valid = 0. trig_chan and trig_time hold.
- arm outside IDLE is ignored. arm coincident with rst: rst wins.
- sample_valid may assert on any cycle, including back to back every cycle.

Test Plan:
All tests use DEPTH_LOG2 = 4, PRE_TRIG = 4, sample n with all channels = 0x2000 + n unless noted, and rd_ready = 1 unless noted.
1. Reset: assert rst 3 cycles with random inputs -> all outputs 0, busy = 0; arm pulse ignored during rst.
2. Basic trigger: threshold = 400, mask = 0xFF; arm, feed samples n = 0..40 with channel C at sample 10 forced to 0x2000+500 (others 0x2000) -> triggered, trig_chan = 2, trig_time = counter at sample 10; 16 words = samples 6..21, word 4 = sample 10, rd_last only on word 15.
3. Negative excursion and mask: channel H = 0x1E6F (mag 401), threshold = 401 -> trig_chan = 7. Repeat with mask = 0x7F -> no trigger, busy stays high.
4. FILL gating: crossing on the 2nd sample after arm is ignored; crossing on the 7th sample triggers -> frame word 4 = 7th sample.
5. Backpressure: rd_ready random at 30% -> rd_data stable while stalled; sequence identical to test 2; exactly 16 handshakes; samples fed during READOUT absent from the next capture.
6. Abort and re-arm: rst during POST -> next cycle IDLE, busy = 0, rd_valid = 0, triggered = 0; arm again -> a correct frame follows. arm during READOUT -> no effect.
